// File: rtl/display_mux_ctrl.sv
// Two-digit display multiplexer: time-slices one seven-segment decoder between two digits,
// with optional segment blanking at each slot start (enabled by defining DISPLAY_MUX_BLANK_EN).
module display_mux_ctrl #(
  parameter int DIV_WIDTH    = 17,
  parameter int BLANK_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  output logic       sel,
  output logic [3:0] digit_out,
  output logic       blank,
  output logic       slot_start
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 sel_q, sel_d;
  logic [3:0]           digit_q, digit_d;
  logic                 slot_start_q, slot_start_d;
  logic                 restart_q, restart_d;
  logic                 wrap;
  logic                 load;

  // restart_q marks the first cycle out of reset: it opens a slot without toggling sel.
  always_comb begin
    wrap         = (cnt_q == {DIV_WIDTH{1'b1}});
    load         = restart_q | wrap;
    cnt_d        = restart_q ? '0 : cnt_q + 1'b1;
    sel_d        = wrap ? ~sel_q : sel_q;
    slot_start_d = load;
    digit_d      = load ? (sel_d ? digit0 : digit1) : digit_q;
    restart_d    = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      sel_q        <= 1'b0;
      digit_q      <= 4'h0;
      slot_start_q <= 1'b0;
      restart_q    <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      digit_q      <= digit_d;
      slot_start_q <= slot_start_d;
      restart_q    <= restart_d;
    end
  end

`ifdef DISPLAY_MUX_BLANK_EN
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  localparam logic [DIV_WIDTH-1:0] BLANK_LIM = DIV_WIDTH'(BLANK_CYCLES);
  localparam bit                   HAS_BLANK = (BLANK_CYCLES > 0);

  state_t state_q, state_d;
  logic   blank_q, blank_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HAS_BLANK ? ST_BLANK : ST_SHOW;
      blank_q <= HAS_BLANK;
    end else begin
      state_q <= state_d;
      blank_q <= blank_d;
    end
  end

  // Transitions look at the count the next cycle will carry, so blank lines up with cnt.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: if (cnt_d == BLANK_LIM) state_d = ST_SHOW;
      ST_SHOW:  if (load && HAS_BLANK)  state_d = ST_BLANK;
      default:  state_d = ST_BLANK;
    endcase
  end

  always_comb begin
    blank_d = (state_d == ST_BLANK);
  end

  assign blank = blank_q;
`else
  assign blank = 1'b0;
`endif

  assign sel        = sel_q;
  assign digit_out  = digit_q;
  assign slot_start = slot_start_q;

endmodule

// File: tb/tb_display_mux_ctrl.sv
// Directed bench for display_mux_ctrl (DIV_WIDTH=4, BLANK_CYCLES=3 plus a BLANK_CYCLES=0 copy).
module tb_display_mux_ctrl;

`ifdef DISPLAY_MUX_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] digit0, digit1;
  logic       sel, blank, slot_start;
  logic [3:0] digit_out;
  logic       sel_z, blank_z, slot_start_z;
  logic [3:0] digit_out_z;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_dout;

  always #5 clk = ~clk;

  display_mux_ctrl #(.DIV_WIDTH(4), .BLANK_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .digit0(digit0), .digit1(digit1),
    .sel(sel), .digit_out(digit_out), .blank(blank), .slot_start(slot_start)
  );

  display_mux_ctrl #(.DIV_WIDTH(4), .BLANK_CYCLES(0)) dut_z (
    .clk(clk), .reset(reset), .digit0(digit0), .digit1(digit1),
    .sel(sel_z), .digit_out(digit_out_z), .blank(blank_z), .slot_start(slot_start_z)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state();
    check("rst_sel", int'(sel), 0);
    check("rst_dout", int'(digit_out), 0);
    check("rst_ss", int'(slot_start), 0);
    check("rst_blank", int'(blank), BLANK_EN ? 1 : 0);
    check("rst_blank_z", int'(blank_z), 0);
    check("rst_sel_z", int'(sel_z), 0);
  endtask

  // k counts cycles since the slot-start cycle that follows reset release.
  task automatic check_cycle(input int k);
    int pos;
    int exp_sel;
    pos     = k % 16;
    exp_sel = (k / 16) % 2;
    if (pos == 0) exp_dout = (exp_sel == 1) ? digit0 : digit1;
    check("sel", int'(sel), exp_sel);
    check("slot_start", int'(slot_start), (pos == 0) ? 1 : 0);
    check("digit_out", int'(digit_out), int'(exp_dout));
    check("blank", int'(blank), (BLANK_EN && pos < 3) ? 1 : 0);
    check("sel_z", int'(sel_z), exp_sel);
    check("slot_start_z", int'(slot_start_z), (pos == 0) ? 1 : 0);
    check("digit_out_z", int'(digit_out_z), int'(exp_dout));
    check("blank_z", int'(blank_z), 0);
    if (pos == 0)
      $display("slot k=%0d sel=%0d digit_out=%0h blank=%0d slot_start=%0d",
               k, sel, digit_out, blank, slot_start);
  endtask

  initial begin
    reset  = 1'b1;
    digit0 = 4'hA;
    digit1 = 4'h5;
    exp_dout = 4'h0;

    @(posedge clk); #1;
    check_reset_state();
    @(posedge clk); #1;
    check_reset_state();
    reset = 1'b0;

    // Free run over five slots; digit0 changes mid-way through the first sel=1 slot.
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      check_cycle(k);
      if (k == 24) begin
        digit0 = 4'h3;
        $display("digit0 -> 3 at k=%0d (slot cycle 8, sel=%0d)", k, sel);
      end
    end

    // Last sample was cnt=15: reset lands on the wrap edge and must win.
    reset = 1'b1;
    @(posedge clk); #1;
    $display("reset on wrap edge: sel=%0d digit_out=%0h slot_start=%0d blank=%0d",
             sel, digit_out, slot_start, blank);
    check_reset_state();
    reset = 1'b0;

    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check_cycle(k);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_mux_ctrl.md
DISPLAY_MUX_CTRL -- requirements
Module: display_mux_ctrl

Interface
REQ-001 Parameter: DIV_WIDTH, default 17, width of the slot counter; slot length is 2^DIV_WIDTH clk cycles.
REQ-002 Parameter: BLANK_CYCLES, default 64, cycles of segment blanking at the start of each slot; legal range 0 to 2^DIV_WIDTH-1.
REQ-003 Port: clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 Port: digit0  input  4  hex value for the first display digit.
REQ-006 Port: digit1  input  4  hex value for the second display digit.
REQ-007 Port: sel  output  1  digit select to the downstream anode switch; 1 = first digit, 0 = second digit.
REQ-008 Port: digit_out  output  4  captured hex value for the currently selected digit, feeding the seven-segment decoder.
REQ-009 Port: blank  output  1  1 = decoder drives all segments off.
REQ-010 Port: slot_start  output  1  one-cycle pulse marking the first cycle of each new slot.

Function
REQ-011 The block SHALL hold a free-running DIV_WIDTH-bit counter cnt that increments by 1 every cycle and wraps from 2^DIV_WIDTH-1 to 0.
REQ-012 On the edge where cnt wraps, the block SHALL toggle sel, assert slot_start for exactly the following cycle, and load digit_out with digit0 if the new sel is 1, else digit1.
REQ-013 digit_out SHALL stay constant for the whole slot; digit0 and digit1 changes mid-slot SHALL NOT appear until the next load.
REQ-014 blank SHALL be a registered output equal to 1 exactly while cnt < BLANK_CYCLES, giving BLANK_CYCLES blank cycles starting with the slot_start cycle.
REQ-015 With BLANK_CYCLES = 0, blank SHALL be constantly 0.
REQ-016 Two states: BLANK (cnt < BLANK_CYCLES) and SHOW; BLANK->SHOW when cnt reaches BLANK_CYCLES; SHOW->BLANK on wrap; state and blank SHALL be mutually consistent every cycle.
REQ-017 sel, digit_out and blank SHALL all be registered, with no combinational path from digit0 or digit1 to any output.
REQ-018 The first cycle after reset deasserts SHALL behave as a slot start with sel = 0: digit_out loads digit1, slot_start = 1, and blanking runs.

Reset
REQ-019 While reset = 1 on a clk edge, the block SHALL set cnt = 0, sel = 0, digit_out = 4'h0, slot_start = 0, and state = BLANK.
REQ-020 While reset = 1 on a clk edge, blank SHALL be 1 if BLANK_CYCLES > 0 and the blanking feature is compiled in, else 0.
REQ-021 Reset asserted mid-slot SHALL abandon the slot with no residual toggle or pulse; REQ-018 applies on release.
REQ-022 Reset SHALL take priority over a simultaneous wrap.

Configuration
REQ-023 Macro DISPLAY_MUX_BLANK_EN defined: blanking behaves per REQ-014 to REQ-016.
REQ-024 Macro DISPLAY_MUX_BLANK_EN undefined: blank is tied to 0, the BLANK state is omitted, and all other behaviour is unchanged.

Verification (DIV_WIDTH = 4, BLANK_CYCLES = 3, macro defined unless noted)
REQ-025 Reset held for 2 cycles, then released, with digit0 = 4'hA and digit1 = 4'h5 -> first cycle: sel = 0, digit_out = 5, slot_start = 1, blank = 1 for 3 cycles then 0.
REQ-026 Free run for 64 cycles -> sel toggles every 16 cycles; slot_start gives 4 single-cycle pulses; digit_out alternates A/5 in step with sel = 1/0.
REQ-027 digit0 changed from A to 3 at slot cycle 8 of a sel = 1 slot -> digit_out stays A until the next sel = 1 slot, then shows 3.
REQ-028 Reset asserted at cnt = 15 (wrap cycle) -> no toggle; outputs equal the reset values on the next cycle.
REQ-029 Macro undefined, same stimulus as REQ-026 -> blank = 0 every cycle; sel and digit_out identical to the REQ-026 run.
REQ-030 BLANK_CYCLES = 0 -> blank never asserts; slot_start and sel timing unchanged.
